// File: rtl/cpu_control.sv
// Multi-cycle control sequencer: FETCH/EXEC/COMMIT per instruction, decodes
// ALU and register-file controls, resolves branches and owns the PC.
module cpu_control #(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter int unsigned REG_ADDR_W = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           INSTRUCTION,
  input  logic                  INSTR_VALID,
  output logic                  INSTR_READY,
  input  logic                  ZERO,
  output logic [31:0]           PC,
  output logic [2:0]            ALUOP,
  output logic [7:0]            IMMEDIATE,
  output logic                  IMM_SEL,
  output logic                  NEG_SEL,
  output logic [REG_ADDR_W-1:0] READREG1,
  output logic [REG_ADDR_W-1:0] READREG2,
  output logic [REG_ADDR_W-1:0] WRITEREG,
  output logic                  WRITEENABLE,
  output logic                  ILLEGAL
);

  typedef enum logic [1:0] {FETCH, EXEC, COMMIT} state_e;

  state_e                state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic                  ready_q, ready_d;
  logic [2:0]            aluop_q, aluop_d;
  logic [7:0]            imm_q, imm_d;
  logic                  imm_sel_q, imm_sel_d;
  logic                  neg_sel_q, neg_sel_d;
  logic [REG_ADDR_W-1:0] rr1_q, rr1_d;
  logic [REG_ADDR_W-1:0] rr2_q, rr2_d;
  logic [REG_ADDR_W-1:0] wr_q, wr_d;
  logic                  we_q, we_d;
  logic                  ill_q, ill_d;
  logic [7:0]            op_q, op_d;
  logic [7:0]            off_q, off_d;

  logic [2:0]            dec_aluop;
  logic                  dec_imm_sel;
  logic                  dec_neg_sel;
  logic                  taken;
  logic [31:0]           branch_off;
  logic                  unused_rt;

  // Only the low REG_ADDR_W bits of the RT field address the register file.
  assign unused_rt = ^INSTRUCTION[15:8];

  // Opcode decode of the word presented at the handshake.
  always_comb begin
    dec_aluop   = 3'b000;
    dec_imm_sel = 1'b0;
    dec_neg_sel = 1'b0;
    case (INSTRUCTION[31:24])
      8'h00: dec_imm_sel = 1'b1;
      8'h02: dec_aluop   = 3'b001;
      8'h03: begin dec_aluop = 3'b001; dec_neg_sel = 1'b1; end
      8'h04: dec_aluop   = 3'b010;
      8'h05: dec_aluop   = 3'b011;
      8'h06: dec_aluop   = 3'b100;
      8'h07: begin dec_aluop = 3'b001; dec_neg_sel = 1'b1; end
      default: ;
    endcase
  end

  assign taken      = (op_q == 8'h06) || ((op_q == 8'h07) && ZERO);
  assign branch_off = {{22{off_q[7]}}, off_q, 2'b00};

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ready_d   = ready_q;
    aluop_d   = aluop_q;
    imm_d     = imm_q;
    imm_sel_d = imm_sel_q;
    neg_sel_d = neg_sel_q;
    rr1_d     = rr1_q;
    rr2_d     = rr2_q;
    wr_d      = wr_q;
    we_d      = we_q;
    ill_d     = ill_q;
    op_d      = op_q;
    off_d     = off_q;
    case (state_q)
      FETCH: begin
        if (INSTR_VALID) begin
          op_d      = INSTRUCTION[31:24];
          off_d     = INSTRUCTION[23:16];
          imm_d     = INSTRUCTION[7:0];
          rr1_d     = INSTRUCTION[8 +: REG_ADDR_W];
          rr2_d     = INSTRUCTION[0 +: REG_ADDR_W];
          wr_d      = INSTRUCTION[16 +: REG_ADDR_W];
          aluop_d   = dec_aluop;
          imm_sel_d = dec_imm_sel;
          neg_sel_d = dec_neg_sel;
          ready_d   = 1'b0;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        we_d    = (op_q < 8'h06);
        state_d = COMMIT;
      end
      COMMIT: begin
        we_d    = 1'b0;
        pc_d    = pc_q + 32'd4 + (taken ? branch_off : 32'd0);
        ill_d   = ill_q | (op_q > 8'h07);
        ready_d = 1'b1;
        state_d = FETCH;
      end
      default: begin
        ready_d = 1'b1;
        state_d = FETCH;
      end
    endcase
  end

  // State register with synchronous reset; reset also abandons any in-flight op.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= FETCH;
      pc_q      <= PC_RESET;
      ready_q   <= 1'b1;
      aluop_q   <= 3'b000;
      imm_q     <= 8'h00;
      imm_sel_q <= 1'b0;
      neg_sel_q <= 1'b0;
      rr1_q     <= '0;
      rr2_q     <= '0;
      wr_q      <= '0;
      we_q      <= 1'b0;
      ill_q     <= 1'b0;
      op_q      <= 8'h00;
      off_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ready_q   <= ready_d;
      aluop_q   <= aluop_d;
      imm_q     <= imm_d;
      imm_sel_q <= imm_sel_d;
      neg_sel_q <= neg_sel_d;
      rr1_q     <= rr1_d;
      rr2_q     <= rr2_d;
      wr_q      <= wr_d;
      we_q      <= we_d;
      ill_q     <= ill_d;
      op_q      <= op_d;
      off_q     <= off_d;
    end
  end

  assign PC          = pc_q;
  assign INSTR_READY = ready_q;
  assign ALUOP       = aluop_q;
  assign IMMEDIATE   = imm_q;
  assign IMM_SEL     = imm_sel_q;
  assign NEG_SEL     = neg_sel_q;
  assign READREG1    = rr1_q;
  assign READREG2    = rr2_q;
  assign WRITEREG    = wr_q;
  assign WRITEENABLE = we_q;
  assign ILLEGAL     = ill_q;

endmodule

// File: tb/tb_cpu_control.sv
// Self-checking bench for cpu_control: directed scenarios plus randomized
// instruction streams compared against an instruction-level reference model.
module tb_cpu_control;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic        ZERO;
  logic [31:0] PC;
  logic [2:0]  ALUOP;
  logic [7:0]  IMMEDIATE;
  logic        IMM_SEL;
  logic        NEG_SEL;
  logic [2:0]  READREG1;
  logic [2:0]  READREG2;
  logic [2:0]  WRITEREG;
  logic        WRITEENABLE;
  logic        ILLEGAL;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic        m_ill;

  logic [2:0] alu_tbl [8] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd1};

  typedef struct packed {
    logic [2:0]  aluop;
    logic [7:0]  imm;
    logic        imm_sel;
    logic        neg_sel;
    logic [2:0]  rr1;
    logic [2:0]  rr2;
    logic [2:0]  wr;
    logic        rdy_dec;
    logic        we_dec;
    logic        ill_dec;
    logic        rdy_exec;
    logic        we_exec;
    logic        ill_exec;
    logic        we_post;
    logic        rdy_post;
    logic        ill_post;
    logic [31:0] pc_post;
  } obs_t;

  cpu_control #(.PC_RESET(32'h0000_0000), .REG_ADDR_W(3)) dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .ZERO(ZERO), .PC(PC), .ALUOP(ALUOP),
    .IMMEDIATE(IMMEDIATE), .IMM_SEL(IMM_SEL), .NEG_SEL(NEG_SEL),
    .READREG1(READREG1), .READREG2(READREG2), .WRITEREG(WRITEREG),
    .WRITEENABLE(WRITEENABLE), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  // Reference model: per-opcode behaviour at instruction level.
  function automatic logic [2:0] m_aluop(input logic [7:0] op);
    return (op > 8'h07) ? 3'd0 : alu_tbl[op[2:0]];
  endfunction

  function automatic logic m_writes(input logic [7:0] op);
    return op < 8'h06;
  endfunction

  function automatic logic [31:0] m_next_pc(input logic [31:0] pc, input logic [31:0] ins,
                                             input logic z);
    logic [7:0] op;
    logic [7:0] off;
    int         soff;
    op   = ins[31:24];
    off  = ins[23:16];
    soff = int'($signed(off));
    if (op == 8'h06 || (op == 8'h07 && z)) return pc + 32'd4 + 32'(soff * 4);
    return pc + 32'd4;
  endfunction

  // Drives one instruction through its three cycles and records what the DUT shows.
  task automatic exec_instr(input logic [31:0] ins, input logic z, output obs_t o);
    int n = 0;
    while (INSTR_READY !== 1'b1 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 10) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout INSTR_READY=%b after %0d cycles", INSTR_READY, n);
    end
    INSTRUCTION = ins;
    INSTR_VALID = 1'b1;
    ZERO        = 1'($urandom);
    @(negedge CLK);
    o.aluop = ALUOP; o.imm = IMMEDIATE; o.imm_sel = IMM_SEL; o.neg_sel = NEG_SEL;
    o.rr1 = READREG1; o.rr2 = READREG2; o.wr = WRITEREG;
    o.rdy_dec = INSTR_READY; o.we_dec = WRITEENABLE; o.ill_dec = ILLEGAL;
    INSTR_VALID = 1'($urandom);
    INSTRUCTION = $urandom;
    ZERO        = ~z;
    @(negedge CLK);
    o.rdy_exec = INSTR_READY; o.we_exec = WRITEENABLE; o.ill_exec = ILLEGAL;
    INSTR_VALID = 1'($urandom);
    INSTRUCTION = $urandom;
    ZERO        = z;
    @(negedge CLK);
    o.we_post = WRITEENABLE; o.rdy_post = INSTR_READY; o.ill_post = ILLEGAL; o.pc_post = PC;
    INSTR_VALID = 1'b0;
    ZERO        = 1'($urandom);
  endtask

  task automatic test_reset();
    RESET = 1'b1; INSTR_VALID = 1'b1; INSTRUCTION = 32'h0002_002A; ZERO = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (INSTR_READY !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", INSTR_READY); end
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 00000000", PC); end
    checks++; if ({ALUOP, IMM_SEL, NEG_SEL, WRITEENABLE, ILLEGAL} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0000000", {ALUOP, IMM_SEL, NEG_SEL, WRITEENABLE, ILLEGAL}); end
    checks++; if ({IMMEDIATE, READREG1, READREG2, WRITEREG} !== 17'b0) begin
      errors++; $display("FAIL reset_fields got %h exp 0", {IMMEDIATE, READREG1, READREG2, WRITEREG}); end
    RESET = 1'b0; INSTR_VALID = 1'b0;
    @(negedge CLK);
    checks++; if (INSTR_READY !== 1'b1 || IMMEDIATE !== 8'h00) begin
      errors++; $display("FAIL reset_no_accept ready=%b imm=%h exp 1/00", INSTR_READY, IMMEDIATE); end
    m_pc = 32'h0; m_ill = 1'b0;
  endtask

  task automatic test_loadi();
    obs_t o;
    exec_instr(32'h0002_002A, 1'b0, o);
    checks++; if (o.aluop !== 3'b000 || o.imm_sel !== 1'b1 || o.neg_sel !== 1'b0) begin
      errors++; $display("FAIL loadi_ctrl got aluop=%b imm_sel=%b neg=%b exp 000/1/0", o.aluop, o.imm_sel, o.neg_sel); end
    checks++; if (o.imm !== 8'h2A || o.wr !== 3'd2) begin
      errors++; $display("FAIL loadi_fields got imm=%h wr=%0d exp 2a/2", o.imm, o.wr); end
    checks++; if ({o.we_dec, o.we_exec, o.we_post} !== 3'b010) begin
      errors++; $display("FAIL loadi_we got %b exp 010", {o.we_dec, o.we_exec, o.we_post}); end
    checks++; if (o.pc_post !== 32'h4) begin errors++; $display("FAIL loadi_pc got %h exp 00000004", o.pc_post); end
    m_pc = 32'h4;
  endtask

  task automatic test_sub_ready();
    obs_t o;
    exec_instr(32'h0303_0102, 1'b1, o);
    checks++; if (o.aluop !== 3'b001 || o.neg_sel !== 1'b1 || o.imm_sel !== 1'b0) begin
      errors++; $display("FAIL sub_ctrl got aluop=%b neg=%b imm_sel=%b exp 001/1/0", o.aluop, o.neg_sel, o.imm_sel); end
    checks++; if (o.rr1 !== 3'd1 || o.rr2 !== 3'd2 || o.wr !== 3'd3) begin
      errors++; $display("FAIL sub_regs got %0d/%0d/%0d exp 1/2/3", o.rr1, o.rr2, o.wr); end
    checks++; if ({o.rdy_dec, o.rdy_exec, o.rdy_post} !== 3'b001) begin
      errors++; $display("FAIL sub_ready got %b exp 001", {o.rdy_dec, o.rdy_exec, o.rdy_post}); end
    checks++; if (o.pc_post !== 32'h8) begin errors++; $display("FAIL sub_pc got %h exp 00000008", o.pc_post); end
    m_pc = 32'h8;
  endtask

  task automatic test_branch();
    obs_t o;
    exec_instr(32'h0601_0000, 1'b0, o);
    checks++; if (o.pc_post !== 32'h10) begin errors++; $display("FAIL jmp_to_10 got %h exp 00000010", o.pc_post); end
    exec_instr(32'h07FE_0102, 1'b1, o);
    checks++; if (o.pc_post !== 32'h0C) begin errors++; $display("FAIL beq_taken_pc got %h exp 0000000c", o.pc_post); end
    checks++; if ({o.we_exec, o.we_post} !== 2'b00 || o.aluop !== 3'b001 || o.neg_sel !== 1'b1) begin
      errors++; $display("FAIL beq_taken_ctrl got we=%b aluop=%b neg=%b exp 00/001/1", {o.we_exec, o.we_post}, o.aluop, o.neg_sel); end
    exec_instr(32'h0600_0000, 1'b1, o);
    checks++; if (o.pc_post !== 32'h10) begin errors++; $display("FAIL jmp_back_10 got %h exp 00000010", o.pc_post); end
    exec_instr(32'h07FE_0102, 1'b0, o);
    checks++; if (o.pc_post !== 32'h14) begin errors++; $display("FAIL beq_not_taken_pc got %h exp 00000014", o.pc_post); end
    checks++; if ({o.we_exec, o.we_post} !== 2'b00) begin
      errors++; $display("FAIL beq_not_taken_we got %b exp 00", {o.we_exec, o.we_post}); end
    m_pc = 32'h14;
  endtask

  task automatic test_jump_wrap();
    obs_t o;
    exec_instr(32'h06F6_0000, 1'b0, o);  // 0x14 + 4 - 40 = 0xFFFFFFF0
    checks++; if (o.pc_post !== 32'hFFFF_FFF0) begin errors++; $display("FAIL jmp_neg_wrap got %h exp fffffff0", o.pc_post); end
    exec_instr(32'h067F_0000, 1'b0, o);
    checks++; if (o.pc_post !== 32'h0000_01F0) begin errors++; $display("FAIL jmp_pos_wrap got %h exp 000001f0", o.pc_post); end
    checks++; if (o.aluop !== 3'b100 || o.we_exec !== 1'b0) begin
      errors++; $display("FAIL jmp_ctrl got aluop=%b we=%b exp 100/0", o.aluop, o.we_exec); end
    m_pc = 32'h0000_01F0;
  endtask

  task automatic test_illegal();
    obs_t o;
    exec_instr(32'h9A01_0203, 1'b1, o);
    checks++; if ({o.ill_dec, o.ill_exec, o.ill_post} !== 3'b001) begin
      errors++; $display("FAIL illegal_timing got %b exp 001", {o.ill_dec, o.ill_exec, o.ill_post}); end
    checks++; if ({o.we_dec, o.we_exec, o.we_post} !== 3'b000 || o.aluop !== 3'b000) begin
      errors++; $display("FAIL illegal_ctrl got we=%b aluop=%b exp 000/000", {o.we_dec, o.we_exec, o.we_post}, o.aluop); end
    checks++; if (o.pc_post !== 32'h0000_01F4) begin errors++; $display("FAIL illegal_pc got %h exp 000001f4", o.pc_post); end
    exec_instr(32'h0201_0203, 1'b0, o);
    checks++; if (o.ill_post !== 1'b1) begin errors++; $display("FAIL illegal_sticky got %b exp 1", o.ill_post); end
    m_pc = 32'h0000_01F8; m_ill = 1'b1;
  endtask

  // Random stream (also back-to-back, since each instruction is offered on the first FETCH cycle).
  task automatic test_random(input int count);
    obs_t        o;
    logic [31:0] ins;
    logic [7:0]  op;
    logic        z;
    for (int i = 0; i < count; i++) begin
      ins = $urandom;
      op  = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(8, 255));
      ins[31:24] = op;
      z   = 1'($urandom);
      exec_instr(ins, z, o);
      checks++; if (o.aluop !== m_aluop(op)) begin
        errors++; $display("FAIL rnd_aluop ins=%h got %b exp %b", ins, o.aluop, m_aluop(op)); end
      checks++; if (o.imm_sel !== (op == 8'h00) || o.neg_sel !== (op == 8'h03 || op == 8'h07)) begin
        errors++; $display("FAIL rnd_sel ins=%h got imm_sel=%b neg=%b", ins, o.imm_sel, o.neg_sel); end
      checks++; if ({o.imm, o.rr1, o.rr2, o.wr} !== {ins[7:0], ins[10:8], ins[2:0], ins[18:16]}) begin
        errors++; $display("FAIL rnd_fields ins=%h got %h", ins, {o.imm, o.rr1, o.rr2, o.wr}); end
      checks++; if ({o.we_dec, o.we_exec, o.we_post} !== {1'b0, m_writes(op), 1'b0}) begin
        errors++; $display("FAIL rnd_we ins=%h got %b exp %b", ins, {o.we_dec, o.we_exec, o.we_post}, {1'b0, m_writes(op), 1'b0}); end
      checks++; if ({o.rdy_dec, o.rdy_exec, o.rdy_post} !== 3'b001) begin
        errors++; $display("FAIL rnd_ready ins=%h got %b exp 001", ins, {o.rdy_dec, o.rdy_exec, o.rdy_post}); end
      m_pc  = m_next_pc(m_pc, ins, z);
      m_ill = m_ill | (op > 8'h07);
      checks++; if (o.pc_post !== m_pc) begin
        errors++; $display("FAIL rnd_pc ins=%h z=%b got %h exp %h", ins, z, o.pc_post, m_pc); end
      checks++; if (o.ill_post !== m_ill) begin
        errors++; $display("FAIL rnd_illegal ins=%h got %b exp %b", ins, o.ill_post, m_ill); end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    INSTRUCTION = 32'h0205_0304; INSTR_VALID = 1'b1;
    @(negedge CLK);
    checks++; if (ALUOP !== 3'b001 || INSTR_READY !== 1'b0) begin
      errors++; $display("FAIL rstmid_exec got aluop=%b ready=%b exp 001/0", ALUOP, INSTR_READY); end
    RESET = 1'b1; INSTR_VALID = 1'b0;
    @(negedge CLK);
    checks++; if (WRITEENABLE !== 1'b0 || PC !== 32'h0 || INSTR_READY !== 1'b1 || ILLEGAL !== 1'b0) begin
      errors++; $display("FAIL rstmid_state got we=%b pc=%h ready=%b ill=%b exp 0/00000000/1/0", WRITEENABLE, PC, INSTR_READY, ILLEGAL); end
    RESET = 1'b0;
    @(negedge CLK);
    checks++; if (WRITEENABLE !== 1'b0 || PC !== 32'h0) begin
      errors++; $display("FAIL rstmid_after got we=%b pc=%h exp 0/00000000", WRITEENABLE, PC); end
    m_pc = 32'h0; m_ill = 1'b0;
    exec_instr(32'h0206_0102, 1'b0, o);
    checks++; if ({o.we_exec, o.we_post} !== 2'b10 || o.pc_post !== 32'h4 || o.wr !== 3'd6) begin
      errors++; $display("FAIL rstmid_fresh got we=%b pc=%h wr=%0d exp 10/00000004/6", {o.we_exec, o.we_post}, o.pc_post, o.wr); end
    m_pc = 32'h4;
  endtask

  initial begin
    test_reset();
    test_loadi();
    test_sub_ready();
    test_branch();
    test_jump_wrap();
    test_illegal();
    test_random(40);
    test_reset_mid();
    test_random(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
